// File: rtl/cordic_iter_param.sv
// Iterative CORDIC: one micro-rotation per clock, sin/cos of a full-turn angle.
// Define CORDIC_VECTOR_EN to add vectoring mode (iMode/iX/iY/oAngle).
module cordic_iter_param #(
   parameter int DATA_W  = 16,
   parameter int ANGLE_W = 20,
   parameter int ITER    = 15,
   parameter int K_INIT  = 19897
) (
   input  logic                      iClk,
   input  logic                      iRst_n,
   input  logic                      iValid,
   output logic                      oReady,
   input  logic [ANGLE_W-1:0]        iTheta,
`ifdef CORDIC_VECTOR_EN
   input  logic                      iMode,
   input  logic signed [DATA_W-1:0]  iX,
   input  logic signed [DATA_W-1:0]  iY,
   output logic [ANGLE_W-1:0]        oAngle,
`endif
   output logic signed [DATA_W-1:0]  oSin,
   output logic signed [DATA_W-1:0]  oCos,
   output logic                      oValid
);
   // state | meaning
   // IDLE  | oReady=1, waiting for iValid
   // RUN   | micro-rotation i_q in progress, requests ignored
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam int XW = DATA_W + 2;
   localparam int ZW = ANGLE_W + 1;
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic signed [XW-1:0] SAT_P = XW'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [XW-1:0] SAT_N = -SAT_P;

   function automatic logic [ANGLE_W-1:0] atan_lut(input int unsigned idx);
      logic [31:0] tab;
      logic [32:0] t;
      case (idx)
         0:  tab = 32'h20000000;  1:  tab = 32'h12E4051E;
         2:  tab = 32'h09FB385B;  3:  tab = 32'h051111D4;
         4:  tab = 32'h028B0D43;  5:  tab = 32'h0145D7E1;
         6:  tab = 32'h00A2F61E;  7:  tab = 32'h00517C55;
         8:  tab = 32'h0028BE53;  9:  tab = 32'h00145F2F;
         10: tab = 32'h000A2F98;  11: tab = 32'h000517CC;
         12: tab = 32'h00028BE6;  13: tab = 32'h000145F3;
         14: tab = 32'h0000A2FA;  15: tab = 32'h0000517D;
         16: tab = 32'h000028BE;  17: tab = 32'h0000145F;
         18: tab = 32'h00000A30;  19: tab = 32'h00000518;
         20: tab = 32'h0000028C;  21: tab = 32'h00000146;
         22: tab = 32'h000000A3;  23: tab = 32'h00000051;
         default: tab = 32'h0;
      endcase
      t = {1'b0, tab} + (33'd1 << (31 - ANGLE_W));
      return ANGLE_W'(t >> (32 - ANGLE_W));
   endfunction

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
      logic signed [XW-1:0] r;
      r = v;
      if (v > SAT_P) r = SAT_P;
      else if (v < SAT_N) r = SAT_N;
      return r[DATA_W-1:0];
   endfunction

   logic [0:0]               state_q;
   logic [CW-1:0]            i_q;
   logic signed [XW-1:0]     x_q, y_q, x_d, y_d, x_ld, y_ld, s_raw, c_raw;
   logic signed [ZW-1:0]     z_q, z_d, z_ld, atan_z;
   logic [1:0]               quad_q;
   logic                     neg_dir;
   logic signed [DATA_W-1:0] sin_q, cos_q;
   logic                     valid_q;
`ifdef CORDIC_VECTOR_EN
   logic                     mode_q;
   logic [ANGLE_W-1:0]       angle_q;
`endif

   always_comb begin
      atan_z  = $signed({1'b0, atan_lut(32'(i_q))});
`ifdef CORDIC_VECTOR_EN
      neg_dir = mode_q ? ~y_q[XW-1] : z_q[ZW-1];
`else
      neg_dir = z_q[ZW-1];
`endif
      if (neg_dir) begin
         x_d = x_q + (y_q >>> i_q);
         y_d = y_q - (x_q >>> i_q);
         z_d = z_q + atan_z;
      end else begin
         x_d = x_q - (y_q >>> i_q);
         y_d = y_q + (x_q >>> i_q);
         z_d = z_q - atan_z;
      end
   end

   // Core result covers the first quadrant; fold back to the requested one.
   always_comb begin
      s_raw = y_d;
      c_raw = x_d;
      case (quad_q)
         2'b01: begin s_raw = x_d;  c_raw = -y_d; end
         2'b10: begin s_raw = -y_d; c_raw = -x_d; end
         2'b11: begin s_raw = -x_d; c_raw = y_d;  end
         default: ;
      endcase
`ifdef CORDIC_VECTOR_EN
      if (mode_q) begin
         s_raw = '0;
         c_raw = x_d;
      end
`endif
   end

   always_comb begin
      x_ld = XW'(K_INIT);
      y_ld = '0;
      z_ld = {3'b000, iTheta[ANGLE_W-3:0]};
`ifdef CORDIC_VECTOR_EN
      // Left half-plane: pre-rotate by 180 deg so the core only sees x >= 0.
      if (iMode) begin
         x_ld = iX[DATA_W-1] ? -XW'(iX) : XW'(iX);
         y_ld = iX[DATA_W-1] ? -XW'(iY) : XW'(iY);
         z_ld = iX[DATA_W-1] ? {2'b01, {(ANGLE_W-1){1'b0}}} : '0;
      end
`endif
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         quad_q  <= '0;
         sin_q   <= '0;
         cos_q   <= '0;
         valid_q <= 1'b0;
`ifdef CORDIC_VECTOR_EN
         mode_q  <= 1'b0;
         angle_q <= '0;
`endif
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (iValid) begin
                  x_q     <= x_ld;
                  y_q     <= y_ld;
                  z_q     <= z_ld;
                  quad_q  <= iTheta[ANGLE_W-1:ANGLE_W-2];
                  i_q     <= '0;
                  state_q <= S_RUN;
`ifdef CORDIC_VECTOR_EN
                  mode_q  <= iMode;
`endif
               end
            end
            default: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               if (i_q == CW'(ITER - 1)) begin
                  sin_q   <= sat(s_raw);
                  cos_q   <= sat(c_raw);
                  valid_q <= 1'b1;
                  i_q     <= '0;
                  state_q <= S_IDLE;
`ifdef CORDIC_VECTOR_EN
                  angle_q <= mode_q ? z_d[ANGLE_W-1:0] : '0;
`endif
               end else begin
                  i_q <= i_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign oReady = (state_q == S_IDLE);
   assign oValid = valid_q;
   assign oSin   = sin_q;
   assign oCos   = cos_q;
`ifdef CORDIC_VECTOR_EN
   assign oAngle = angle_q;
`endif

endmodule

// File: tb/tb_cordic_iter_param.sv
// Scoreboard bench for cordic_iter_param: expected sin/cos (and vectoring
// magnitude/angle when CORDIC_VECTOR_EN is defined) come from real-valued math.
module tb_cordic_iter_param;
   localparam real PI = 3.14159265358979;
   localparam int  LAT = 15;

   logic               iClk = 1'b0;
   logic               iRst_n;
   logic               iValid;
   logic               oReady;
   logic [19:0]        iTheta;
   logic signed [15:0] oSin, oCos;
   logic               oValid;
`ifdef CORDIC_VECTOR_EN
   logic               iMode;
   logic signed [15:0] iX, iY;
   logic [19:0]        oAngle;
`endif

   cordic_iter_param dut (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iValid (iValid),
      .oReady (oReady),
      .iTheta (iTheta),
`ifdef CORDIC_VECTOR_EN
      .iMode  (iMode),
      .iX     (iX),
      .iY     (iY),
      .oAngle (oAngle),
`endif
      .oSin   (oSin),
      .oCos   (oCos),
      .oValid (oValid)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      int s;
      int c;
      int ang;
      bit vec;
      int due;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_s = 0;
   int   last_c = 0;

   always @(posedge iClk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp, input int tol);
      int d;
      total++;
      d = got - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, got, exp, tol, cyc);
      end
   endtask

   function automatic int sat_r(input real r);
      int v;
      v = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
      if (v > 32767) v = 32767;
      if (v < -32767) v = -32767;
      return v;
   endfunction

   task automatic send(input logic [19:0] th, input bit vec, input int x, input int y,
                       output bit v_issue);
      int   n;
      exp_t e;
      real  a;
      n = 0;
      @(negedge iClk);
      while (!oReady && n < 100) begin
         @(negedge iClk);
         n++;
      end
      if (!oReady) chk("ready_timeout", 0, 1, 0);
      v_issue = oValid;
      iValid  = 1'b1;
      iTheta  = th;
`ifdef CORDIC_VECTOR_EN
      iMode = vec;
      iX    = 16'(x);
      iY    = 16'(y);
`endif
      @(posedge iClk);
      #1;
      iValid = 1'b0;
      iTheta = 20'($urandom);
`ifdef CORDIC_VECTOR_EN
      iX = 16'($urandom);
      iY = 16'($urandom);
`endif
      if (vec) begin
         e.s   = 0;
         e.c   = sat_r(1.64676 * $sqrt(real'(x) * x + real'(y) * y));
         a     = $atan2(real'(y), real'(x)) / (2.0 * PI) * 1048576.0;
         e.ang = $rtoi(a >= 0.0 ? a + 0.5 : a + 1048576.0 + 0.5) % 1048576;
      end else begin
         a     = 2.0 * PI * real'(th) / 1048576.0;
         e.s   = sat_r(32767.0 * $sin(a));
         e.c   = sat_r(32767.0 * $cos(a));
         e.ang = 0;
      end
      e.vec = vec;
      e.due = cyc + LAT;
      sb.push_back(e);
   endtask

   always @(negedge iClk) begin
      if (iRst_n && oValid) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 1, 0, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("latency", cyc, mon_e.due, 0);
            chk("sin", int'(oSin), mon_e.s, 8);
            chk("cos", int'(oCos), mon_e.c, 8);
            last_s = mon_e.s;
            last_c = mon_e.c;
`ifdef CORDIC_VECTOR_EN
            if (mon_e.vec) begin
               int d;
               d = (int'(oAngle) - mon_e.ang) & 32'hFFFFF;
               if (d >= 524288) d -= 1048576;
               chk("angle_err", d, 0, 16);
            end
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   logic [19:0] thetas [0:11];
   bit          vi;
   int          n;

   initial begin
      thetas[0] = 20'h00000; thetas[1] = 20'h40000; thetas[2]  = 20'hA0000;
      thetas[3] = 20'h20000; thetas[4] = 20'h60000; thetas[5]  = 20'hE0000;
      thetas[6] = 20'hFFFFF; thetas[7] = 20'h3FFFF; thetas[8]  = 20'h80000;
      thetas[9] = 20'($urandom); thetas[10] = 20'($urandom); thetas[11] = 20'($urandom);

      iRst_n = 1'b0;
      iValid = 1'b0;
      iTheta = '0;
`ifdef CORDIC_VECTOR_EN
      iMode = 1'b0;
      iX    = '0;
      iY    = '0;
`endif
      repeat (3) @(negedge iClk);
      chk("rst_ready", int'(oReady), 1, 0);
      chk("rst_valid", int'(oValid), 0, 0);
      chk("rst_sin", int'(oSin), 0, 0);
      chk("rst_cos", int'(oCos), 0, 0);
      iRst_n = 1'b1;

      // back-to-back stream: each later request issued in the previous oValid cycle
      for (int k = 0; k < 12; k++) begin
         send(thetas[k], 1'b0, 0, 0, vi);
         if (k > 0) chk("b2b_issue_in_valid", int'(vi), 1, 0);
      end

      // request pulsed while busy must be dropped
      send(20'h60000, 1'b0, 0, 0, vi);
      repeat (3) @(negedge iClk);
      chk("busy_ready", int'(oReady), 0, 0);
      iValid = 1'b1;
      iTheta = 20'h12345;
      @(negedge iClk);
      iValid = 1'b0;

      // reset while i=7
      send(20'h10000, 1'b0, 0, 0, vi);
      repeat (8) @(negedge iClk);
      iRst_n = 1'b0;
      sb.delete();
      @(negedge iClk);
      chk("abort_sin", int'(oSin), 0, 0);
      chk("abort_cos", int'(oCos), 0, 0);
      chk("abort_ready", int'(oReady), 1, 0);
      chk("abort_valid", int'(oValid), 0, 0);
      iRst_n = 1'b1;
      repeat (20) @(negedge iClk);
      send(20'h20000, 1'b0, 0, 0, vi);

`ifdef CORDIC_VECTOR_EN
      send(20'h0, 1'b1, 10000, 10000, vi);
      send(20'h0, 1'b1, -10000, 0, vi);
      send(20'h0, 1'b1, 3000, -12000, vi);
      send(20'h0, 1'b1, -20000, -5000, vi);
      send(20'h50000, 1'b0, 0, 0, vi);
`endif

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge iClk);
         n++;
      end
      chk("drain_left", sb.size(), 0, 0);

      repeat (5) @(negedge iClk);
      chk("hold_sin", int'(oSin), last_s, 8);
      chk("hold_cos", int'(oCos), last_c, 8);
      chk("idle_valid", int'(oValid), 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
